// File: rtl/auth_pkg.sv
// Shared types and default sizing for the OTP authentication session sequencer.
// State encodings double as the debug code driven on state_dbg.
package auth_pkg;

    localparam int DIGIT_W            = 4;
    localparam int DEF_NUM_DIGITS     = 4;
    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_LOCKED = 3'd5
    } auth_state_e;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for a raw pad button.
// o_pulse is high for one cycle, consumed by the FSM on the 3rd clk edge after the pin rises.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // A held button keeps r_sync and r_prev equal, so only the first cycle fires.
    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/auth_session_ctrl.sv
// OTP session sequencer: snapshot LFSR, collect digits, judge, count failures, lock out.
// Button events act 3 clk after the pin rises; otp_capture and otp_value update on the same edge.
module auth_session_ctrl
    import auth_pkg::*;
#(
    parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               otp_latch,
    input  logic                               user_latch,
    input  logic [DIGIT_W-1:0]                 user_digit,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]      lfsr_value,
    output logic                               otp_capture,
    output logic [DIGIT_W*NUM_DIGITS-1:0]      otp_value,
    output logic                               otp_show,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_idx,
    output logic                               pass,
    output logic                               fail,
    output logic                               locked,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  attempts_left,
    output logic [2:0]                         state_dbg
);

    localparam int OTP_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

    auth_state_e        r_state;
    auth_state_e        w_state_nxt;
    logic [OTP_W-1:0]   r_otp;
    logic [OTP_W-1:0]   w_otp_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_mis;
    logic               w_mis_nxt;
    logic [ATT_W-1:0]   r_att;
    logic [ATT_W-1:0]   w_att_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [LCK_W-1:0]   r_lck;
    logic [LCK_W-1:0]   w_lck_nxt;
    logic               r_cap;
    logic               w_cap_nxt;
    logic               w_otp_ev;
    logic               w_user_ev;
    logic               w_do_cap;
    logic               w_do_fail;
    logic [DIGIT_W-1:0] w_exp_digit;

    btn_edge_sync u_otp_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (otp_latch),
        .o_pulse (w_otp_ev)
    );

    btn_edge_sync u_user_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (user_latch),
        .o_pulse (w_user_ev)
    );

    // Digit 0 is the most-significant nibble of the captured OTP.
    always_comb begin
        w_exp_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_exp_digit = r_otp[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_otp_nxt   = r_otp;
        w_idx_nxt   = r_idx;
        w_mis_nxt   = r_mis;
        w_att_nxt   = r_att;
        w_tmo_nxt   = r_tmo;
        w_lck_nxt   = r_lck;
        w_cap_nxt   = 1'b0;
        w_do_cap    = 1'b0;
        w_do_fail   = 1'b0;
        case (r_state)
            ST_IDLE: w_do_cap = w_otp_ev;
            ST_ENTRY: begin
                if (w_otp_ev) begin
                    w_do_cap = 1'b1;
                end else if (w_user_ev) begin
                    w_mis_nxt = r_mis | (user_digit != w_exp_digit);
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_tmo_nxt = '0;
                    if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_do_fail = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (r_mis) begin
                    w_do_fail = 1'b1;
                end else begin
                    w_state_nxt = ST_PASS;
                    w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
                    w_otp_nxt   = '0;
                end
            end
            ST_PASS: w_do_cap = w_otp_ev;
            ST_FAIL: begin
                if (r_att == '0) begin
                    w_state_nxt = ST_LOCKED;
                    w_lck_nxt   = '0;
                end else begin
                    w_do_cap = w_otp_ev;
                end
            end
            ST_LOCKED: begin
                if (r_lck == LCK_W'(LOCKOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
                    w_lck_nxt   = '0;
                end else begin
                    w_lck_nxt = r_lck + LCK_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A capture always restarts the session; any digit arriving with it is dropped.
        if (w_do_cap) begin
            w_state_nxt = ST_ENTRY;
            w_otp_nxt   = lfsr_value;
            w_idx_nxt   = '0;
            w_mis_nxt   = 1'b0;
            w_tmo_nxt   = '0;
            w_cap_nxt   = 1'b1;
        end
        if (w_do_fail) begin
            w_state_nxt = ST_FAIL;
            w_att_nxt   = (r_att == '0) ? '0 : r_att - ATT_W'(1);
            w_otp_nxt   = '0;
            w_tmo_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_otp <= '0;
            r_idx <= '0;
            r_mis <= 1'b0;
            r_att <= ATT_W'(MAX_ATTEMPTS);
            r_tmo <= '0;
            r_lck <= '0;
            r_cap <= 1'b0;
        end else begin
            r_otp <= w_otp_nxt;
            r_idx <= w_idx_nxt;
            r_mis <= w_mis_nxt;
            r_att <= w_att_nxt;
            r_tmo <= w_tmo_nxt;
            r_lck <= w_lck_nxt;
            r_cap <= w_cap_nxt;
        end
    end

    assign otp_capture   = r_cap;
    assign otp_value     = r_otp;
    assign otp_show      = (r_state == ST_ENTRY);
    assign digit_idx     = r_idx;
    assign pass          = (r_state == ST_PASS);
    assign fail          = (r_state == ST_FAIL);
    assign locked        = (r_state == ST_LOCKED);
    assign attempts_left = r_att;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_auth_session_ctrl.sv
// Directed bench for auth_session_ctrl with a session-level reference model checked every cycle.
module tb_auth_session_ctrl;

    localparam int ND = 4;
    localparam int MA = 3;
    localparam int LC = 16;
    localparam int TC = 64;

    localparam int PH_IDLE   = 0;
    localparam int PH_ENTRY  = 1;
    localparam int PH_CHECK  = 2;
    localparam int PH_PASS   = 3;
    localparam int PH_FAIL   = 4;
    localparam int PH_LOCKED = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        otp_latch;
    logic        user_latch;
    logic [3:0]  user_digit;
    logic [15:0] lfsr_value;
    logic        otp_capture;
    logic [15:0] otp_value;
    logic        otp_show;
    logic [2:0]  digit_idx;
    logic        pass;
    logic        fail;
    logic        locked;
    logic [1:0]  attempts_left;
    logic [2:0]  state_dbg;

    int n_chk = 0;
    int n_err = 0;

    auth_session_ctrl #(
        .NUM_DIGITS     (ND),
        .MAX_ATTEMPTS   (MA),
        .LOCKOUT_CYCLES (LC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .otp_latch     (otp_latch),
        .user_latch    (user_latch),
        .user_digit    (user_digit),
        .lfsr_value    (lfsr_value),
        .otp_capture   (otp_capture),
        .otp_value     (otp_value),
        .otp_show      (otp_show),
        .digit_idx     (digit_idx),
        .pass          (pass),
        .fail          (fail),
        .locked        (locked),
        .attempts_left (attempts_left),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session-level model: button pins seen through a 3-cycle event delay.
    int          m_phase;
    int          m_entered;
    int          m_att;
    int          m_idle;
    int          m_lock;
    bit          m_bad;
    bit          m_cap;
    logic [15:0] m_otp;
    bit          ho [0:3];
    bit          hu [0:3];

    function automatic logic [3:0] expect_digit(input logic [15:0] otp, input int i);
        logic [15:0] t;
        t = otp >> (4 * (ND - 1 - i));
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_entered = 0; m_att = MA; m_idle = 0; m_lock = 0;
        m_bad = 0; m_cap = 0; m_otp = '0;
        for (int i = 0; i < 4; i++) begin
            ho[i] = 0;
            hu[i] = 0;
        end
    endtask

    task automatic start_session();
        m_otp = lfsr_value; m_entered = 0; m_bad = 0; m_idle = 0; m_cap = 1; m_phase = PH_ENTRY;
    endtask

    task automatic fail_session();
        m_phase = PH_FAIL;
        if (m_att > 0) m_att--;
        m_otp = '0;
    endtask

    task automatic model_step();
        bit oe;
        bit ue;
        for (int i = 3; i > 0; i--) begin
            ho[i] = ho[i-1];
            hu[i] = hu[i-1];
        end
        ho[0] = otp_latch;
        hu[0] = user_latch;
        oe = ho[2] & !ho[3];
        ue = hu[2] & !hu[3];
        m_cap = 0;
        case (m_phase)
            PH_IDLE, PH_PASS: if (oe) start_session();
            PH_ENTRY: begin
                if (oe) start_session();
                else if (ue) begin
                    if (user_digit != expect_digit(m_otp, m_entered)) m_bad = 1;
                    m_entered++;
                    m_idle = 0;
                    if (m_entered == ND) m_phase = PH_CHECK;
                end else begin
                    m_idle++;
                    if (m_idle == TC) fail_session();
                end
            end
            PH_CHECK: begin
                if (m_bad) fail_session();
                else begin
                    m_phase = PH_PASS; m_att = MA; m_otp = '0;
                end
            end
            PH_FAIL: begin
                if (m_att == 0) begin
                    m_phase = PH_LOCKED; m_lock = 0;
                end else if (oe) start_session();
            end
            PH_LOCKED: begin
                m_lock++;
                if (m_lock == LC) begin
                    m_phase = PH_IDLE; m_att = MA;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("cyc_state", state_dbg, m_phase);
            chk("cyc_otp", otp_value, m_otp);
            chk("cyc_idx", digit_idx, m_entered);
            chk("cyc_att", attempts_left, m_att);
            chk("cyc_cap", otp_capture, m_cap);
            chk("cyc_show", otp_show, m_phase == PH_ENTRY);
            chk("cyc_pass", pass, m_phase == PH_PASS);
            chk("cyc_fail", fail, m_phase == PH_FAIL);
            chk("cyc_locked", locked, m_phase == PH_LOCKED);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns one cycle after the FSM has acted on the event(s).
    task automatic press(input bit do_otp, input bit do_usr, input logic [15:0] lv, input logic [3:0] dg);
        @(negedge clk);
        lfsr_value = lv;
        user_digit = dg;
        otp_latch  = do_otp;
        user_latch = do_usr;
        repeat (2) @(negedge clk);
        otp_latch  = 1'b0;
        user_latch = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_otp(input logic [15:0] lv);
        press(1'b1, 1'b0, lv, user_digit);
    endtask

    task automatic press_user(input logic [3:0] dg);
        press(1'b0, 1'b1, lfsr_value, dg);
    endtask

    task automatic enter4(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) press_user(expect_digit(c, i));
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0; otp_latch = 1'b0; user_latch = 1'b0;
        user_digit = 4'h0; lfsr_value = 16'h0;
        tick(2);
        chk("rst_state", state_dbg, 0);
        chk("rst_att", attempts_left, 3);
        chk("rst_otp", otp_value, 0);
        rst_n = 1'b1;
        tick(2);

        // Correct entry, with capture latency measured from pin rise.
        @(negedge clk);
        lfsr_value = 16'hA5C3;
        otp_latch  = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #2;
            if (otp_capture && lat == 0) lat = i;
        end
        otp_latch = 1'b0;
        tick(1);
        chk("cap_latency", lat, 3);
        chk("t1_otp", otp_value, 16'hA5C3);
        chk("t1_entry", state_dbg, 1);
        enter4(16'hA5C3);
        chk("t1_pass", pass, 1);
        chk("t1_att", attempts_left, 3);
        chk("t1_otp_clr", otp_value, 0);

        // Wrong last digit, then a fresh session.
        press_otp(16'hA5C3);
        enter4(16'hA5C4);
        chk("t2_fail", fail, 1);
        chk("t2_att", attempts_left, 2);
        chk("t2_otp_clr", otp_value, 0);
        press_otp(16'hA5C3);
        chk("t2_reentry", state_dbg, 1);
        chk("t2_idx", digit_idx, 0);

        // Two more failures reach lockout; buttons are ignored while locked.
        enter4(16'h0000);
        chk("t3_att1", attempts_left, 1);
        press_otp(16'hA5C3);
        enter4(16'h0000);
        chk("t3_fail0", fail, 1);
        chk("t3_att0", attempts_left, 0);
        tick(1);
        chk("t3_locked", locked, 1);
        press_otp(16'hA5C3);
        press_user(4'hA);
        chk("t3_ignored", state_dbg, 5);
        n = 10;
        for (int i = 0; i < 40 && state_dbg != 3'd0; i++) begin
            tick(1);
            n++;
        end
        chk("t3_lock_len", n, 16);
        chk("t3_att_reload", attempts_left, 3);

        // Timeout after two digits.
        press_otp(16'hA5C3);
        press_user(4'hA);
        press_user(4'h5);
        tick(62);
        chk("t4_before_tmo", state_dbg, 1);
        tick(1);
        chk("t4_tmo_fail", fail, 1);
        chk("t4_att", attempts_left, 2);

        // Restart mid-entry, and a simultaneous otp/user event.
        press_otp(16'hA5C3);
        press_user(4'hA);
        press_user(4'h5);
        press_otp(16'h1234);
        chk("t5_otp", otp_value, 16'h1234);
        chk("t5_idx", digit_idx, 0);
        chk("t5_att", attempts_left, 2);
        press(1'b1, 1'b1, 16'h1234, 4'h1);
        chk("t5_sim_idx", digit_idx, 0);
        enter4(16'h1234);
        chk("t5_pass", pass, 1);

        // Held button yields one digit; async reset mid-entry.
        press_otp(16'hA5C3);
        @(negedge clk);
        user_digit = 4'hA;
        user_latch = 1'b1;
        tick(20);
        user_latch = 1'b0;
        tick(3);
        chk("t6_hold_idx", digit_idx, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state_dbg, 0);
        chk("t6_rst_otp", otp_value, 0);
        chk("t6_rst_idx", digit_idx, 0);
        chk("t6_rst_show", otp_show, 0);
        chk("t6_rst_att", attempts_left, 3);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t6_post_idle", state_dbg, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/auth_session_ctrl.md
Name: auth_session_ctrl

Overview:
Session sequencer for the tiny hardware authentication engine. It captures a one-time password (OTP) snapshot from the free-running LFSR on an OTP-latch request. It then collects NUM_DIGITS user-entered 4-bit digits and compares them against the snapshot. It reports pass/fail, counts failed attempts, and enforces a timed lockout; it sits between the pad-level latch buttons and the LFSR/7-seg display datapath.

Parameters:
- NUM_DIGITS, 4, OTP length in 4-bit digits; OTP width = 4*NUM_DIGITS.
- MAX_ATTEMPTS, 3, failed sessions allowed before lockout (>=1).
- LOCKOUT_CYCLES, 1024, clk cycles spent in LOCKED.
- TIMEOUT_CYCLES, 4096, max idle cycles between digit entries before a forced fail.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- otp_latch  in  1  raw button level; request a new OTP.
- user_latch  in  1  raw button level; commit current user_digit.
- user_digit  in  4  digit value being entered.
- lfsr_value  in  4*NUM_DIGITS  current LFSR state.
- otp_capture  out  1  one-cycle pulse when the OTP is snapshotted (display freeze).
- otp_value  out  4*NUM_DIGITS  captured OTP; 0 when not valid.
- otp_show  out  1  high in ENTRY; display shows otp_value.
- digit_idx  out  clog2(NUM_DIGITS+1)  digits accepted so far.
- pass  out  1  held high in PASS.
- fail  out  1  held high in FAIL.
- locked  out  1  held high in LOCKED.
- attempts_left  out  clog2(MAX_ATTEMPTS+1)  remaining attempts.
- state_dbg  out  3  encoded FSM state.

Behaviour:
- Reset values:
  - state IDLE.
  - All 1-bit outputs 0.
  - otp_value 0, digit_idx 0.
  - attempts_left = MAX_ATTEMPTS.
  - Timers 0.
- Input conditioning:
  - otp_latch and user_latch each pass through a 2-flop synchronizer plus a rising-edge detector.
  - An event is a 1-cycle internal pulse, 3 clk after the pin rises.
  - A held button produces one event only.
- FSM states:
  - IDLE (0):
    - otp_ev -> capture lfsr_value into otp_value, pulse otp_capture.
    - Clear digit_idx, the mismatch flag and the timeout counter; go to ENTRY.
    - user_ev is ignored.
  - ENTRY (1):
    - user_ev -> compare user_digit with OTP nibble digit_idx (nibble 0 = most-significant); OR any mismatch into a sticky flag.
    - Increment digit_idx and clear the timeout counter.
    - When digit_idx reaches NUM_DIGITS, go to CHECK.
    - No per-digit result is exposed.
  - CHECK (2): exactly 1 cycle.
    - Flag clear -> PASS; flag set -> FAIL.
  - PASS (3):
    - attempts_left reloads to MAX_ATTEMPTS and otp_value clears.
    - otp_ev -> new capture, go to ENTRY.
  - FAIL (4):
    - On entry, attempts_left decrements by 1 and otp_value clears.
    - If the decremented value is 0, go to LOCKED on the next cycle.
    - Otherwise hold FAIL; otp_ev -> new capture, go to ENTRY.
  - LOCKED (5):
    - Both events are ignored.
    - The lockout counter runs LOCKOUT_CYCLES cycles, then the block goes to IDLE with attempts_left = MAX_ATTEMPTS and the counter cleared.
- Timeout:
  - In ENTRY, TIMEOUT_CYCLES consecutive cycles without user_ev -> FAIL.
  - This counts as an attempt.
- Simultaneous events:
  - otp_ev and user_ev in the same ENTRY cycle: otp_ev wins.
  - The OTP is recaptured and entry restarts at digit 0; no attempt is consumed and the digit is dropped.
  - otp_ev alone mid-ENTRY has the same restart behaviour.
- Arithmetic limits:
  - attempts_left never underflows; it saturates at 0.
  - digit_idx never exceeds NUM_DIGITS.
- Mid-operation reset: an asynchronous rst_n assertion at any state returns all outputs and state to reset values immediately.

Decomposition:
- Package auth_pkg holds:
  - The state enum (IDLE..LOCKED, 3-bit).
  - DIGIT_W = 4.
  - Default NUM_DIGITS, MAX_ATTEMPTS, LOCKOUT_CYCLES and TIMEOUT_CYCLES constants.
- Sub-module btn_edge_sync (2-flop synchronizer plus rising-edge pulse), instantiated twice.
- FSM, comparator and counters stay in auth_session_ctrl.

Test Plan:
Common settings: NUM_DIGITS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=64, lfsr_value=16'hA5C3 at capture.

1. Correct entry: otp_latch pulse -> otp_capture 3 clk later, otp_value=A5C3. Digits A,5,C,3 with user_latch -> CHECK 1 cycle, then pass=1, attempts_left=3.
2. Wrong digit: enter A,5,C,4 -> fail=1, attempts_left=2, otp_value=0. A new otp_latch -> ENTRY with digit_idx=0.
3. Lockout: three failed sessions -> locked=1, attempts_left=0. Latches ignored for 16 cycles, then IDLE with attempts_left=3.
4. Timeout: capture, enter 2 digits, then wait 64 cycles -> fail=1, attempts_left decremented.
5. Restart: after 2 digits, otp_latch with lfsr_value=16'h1234 -> otp_value=1234, digit_idx=0, attempts_left unchanged. In a simultaneous otp/user event, the digit is dropped.
6. Reset/button hold: assert rst_n in ENTRY -> all outputs reset immediately. user_latch held high for 20 cycles -> exactly one digit accepted.
